rle_capture_ctrl: RTL and testbench

RLE_CAPTURE_CTRL -- requirements
Module: rle_capture_ctrl

---
 rtl/rle_capture_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rle_capture_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rle_capture_ctrl.sv
// Capture controller: steers raw samples or RLE encoder words into a circular
// sample memory, with pre-trigger fill, trigger wait and post-trigger phases.
module rle_capture_ctrl #(
    parameter int ADDR_W = 24
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_rle_en,
    input  logic [ADDR_W:0]   cfg_depth,
    input  logic [ADDR_W:0]   cfg_pretrig,
    input  logic              trig_hit,
    input  logic [15:0]       raw_data,
    input  logic [15:0]       rle_data,
    input  logic              rle_valid,
    output logic              enc_rst,
    output logic              mem_wr_en,
    output logic [15:0]       mem_wr_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_aborted,
    output logic [ADDR_W-1:0] trig_pos,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    state_t              state_q;
    logic                rle_q;
    logic [ADDR_W:0]     depth_q;
    logic [ADDR_W:0]     pretrig_q;
    logic [ADDR_W:0]     pre_cnt_q;
    logic [ADDR_W:0]     post_cnt_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic                wr_en_q;
    logic [15:0]         wr_data_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [ADDR_W-1:0]   trig_pos_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic                enc_rst_q;

    logic                acc_word;
    logic [15:0]         word_data;
    logic                active;
    logic                wr_word;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W:0]     pretrig_d;
    logic [ADDR_W:0]     pre_cnt_d;
    logic [ADDR_W:0]     post_cnt_d;
    logic [ADDR_W:0]     post_tgt;
    logic                start_ok;

    // Stream contract: there is no back-pressure. A word is accepted whenever
    // the selected source qualifies it, and it is written one cycle later.
    always_comb begin
        acc_word   = rle_q ? rle_valid : 1'b1;
        word_data  = rle_q ? rle_data : raw_data;
        active     = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        wr_word    = active && acc_word;
        ptr_d      = ({1'b0, ptr_q} == (depth_q - CNT_ONE)) ? '0 : ptr_q + PTR_ONE;
        pretrig_d  = (cfg_pretrig >= cfg_depth) ? (cfg_depth - CNT_ONE) : cfg_pretrig;
        pre_cnt_d  = pre_cnt_q + CNT_ONE;
        post_cnt_d = post_cnt_q + CNT_ONE;
        post_tgt   = depth_q - pretrig_q;
        start_ok   = cfg_start && !cfg_stop;
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= S_IDLE;
            rle_q      <= 1'b0;
            depth_q    <= CNT_ONE;
            pretrig_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            trig_pos_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            enc_rst_q  <= 1'b1;
        end else begin
            wr_en_q <= wr_word;
            if (wr_word) begin
                wr_data_q <= word_data;
                wr_addr_q <= ptr_q;
                ptr_q     <= ptr_d;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        rle_q      <= cfg_rle_en;
                        depth_q    <= cfg_depth;
                        pretrig_q  <= pretrig_d;
                        pre_cnt_q  <= '0;
                        post_cnt_q <= '0;
                        ptr_q      <= '0;
                        done_q     <= 1'b0;
                        aborted_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        enc_rst_q  <= 1'b0;
                        state_q    <= (pretrig_d == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE, S_WAIT, S_POST: begin
                    if (cfg_stop) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        enc_rst_q <= 1'b1;
                    end else if (state_q == S_PRE) begin
                        if (acc_word) begin
                            pre_cnt_q <= pre_cnt_d;
                            if (pre_cnt_d == pretrig_q) begin
                                state_q <= S_WAIT;
                            end
                        end
                    end else if (state_q == S_WAIT) begin
                        if (trig_hit) begin
                            trig_pos_q <= ptr_q;
                            state_q    <= S_POST;
                            // The trigger cycle's own word is the first post word;
                            // a one-word post phase therefore finishes right here.
                            if (acc_word) begin
                                post_cnt_q <= CNT_ONE;
                                if (post_tgt == CNT_ONE) begin
                                    state_q   <= S_DONE;
                                    done_q    <= 1'b1;
                                    busy_q    <= 1'b0;
                                    enc_rst_q <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        if (acc_word) begin
                            post_cnt_q <= post_cnt_d;
                            if (post_cnt_d == post_tgt) begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                busy_q    <= 1'b0;
                                enc_rst_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    enc_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign enc_rst     = enc_rst_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
    assign mem_wr_addr = wr_addr_q;
    assign cap_busy    = busy_q;
    assign cap_done    = done_q;
    assign cap_aborted = aborted_q;
    assign trig_pos    = trig_pos_q;
    assign state       = state_q;

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// Bench for rle_capture_ctrl: capture scenarios from a table plus hand-written
// reset and start/stop sequences; memory writes are checked against a queue.
module tb_rle_capture_ctrl;

    localparam int ADDR_W = 24;

    logic              core_clk = 1'b0;
    logic              core_rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_stop = 1'b0;
    logic              cfg_rle_en = 1'b0;
    logic [ADDR_W:0]   cfg_depth = '0;
    logic [ADDR_W:0]   cfg_pretrig = '0;
    logic              trig_hit = 1'b0;
    logic [15:0]       raw_data = '0;
    logic [15:0]       rle_data = '0;
    logic              rle_valid = 1'b0;
    logic              enc_rst;
    logic              mem_wr_en;
    logic [15:0]       mem_wr_data;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              cap_busy;
    logic              cap_done;
    logic              cap_aborted;
    logic [ADDR_W-1:0] trig_pos;
    logic [2:0]        state;

    rle_capture_ctrl #(.ADDR_W(ADDR_W)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_rle_en(cfg_rle_en),
        .cfg_depth(cfg_depth), .cfg_pretrig(cfg_pretrig), .trig_hit(trig_hit),
        .raw_data(raw_data), .rle_data(rle_data), .rle_valid(rle_valid),
        .enc_rst(enc_rst), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_wr_addr(mem_wr_addr), .cap_busy(cap_busy), .cap_done(cap_done),
        .cap_aborted(cap_aborted), .trig_pos(trig_pos), .state(state)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        bit rle;
        int depth;
        int pretrig;
        int trig_cyc;
        int stop_cyc;
        int exp_trig_pos;
        int exp_writes;
        bit exp_aborted;
    } cap_vec_t;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    logic [39:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every memory write must match the oldest expected entry.
    always @(negedge core_clk) begin
        logic [39:0] e;
        if (mem_wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_wr_addr, mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_wr_addr), 64'(e[39:16]));
                chk("wr_data", 64'(mem_wr_data), 64'(e[15:0]));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_enc_rst"}, 64'(enc_rst), 64'd1);
        chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
        chk({tag, "_wr_data"}, 64'(mem_wr_data), 64'd0);
        chk({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'd0);
        chk({tag, "_trig_pos"}, 64'(trig_pos), 64'd0);
        chk({tag, "_busy"}, 64'(cap_busy), 64'd0);
        chk({tag, "_done"}, 64'(cap_done), 64'd0);
        chk({tag, "_aborted"}, 64'(cap_aborted), 64'd0);
        chk({tag, "_state"}, 64'(state), 64'd0);
    endtask

    task automatic drive_words(input bit rle, input int c);
        raw_data  = 16'($urandom_range(0, 65535));
        rle_data  = 16'($urandom_range(0, 65535));
        rle_valid = rle ? (c > 0 && (c % 3) == 0) : 1'($urandom_range(0, 1));
    endtask

    task automatic run_capture(input cap_vec_t v);
        int pushed;
        bit fin;
        logic [15:0] d;
        pushed = 0;
        fin = 0;
        wr_seen = 0;
        cfg_rle_en  = v.rle;
        cfg_depth   = 25'(v.depth);
        cfg_pretrig = 25'(v.pretrig);
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge core_clk);
            if (c > 0 && state == 3'd4) begin
                fin = 1;
            end else begin
                cfg_start = (c == 0);
                cfg_stop  = (v.stop_cyc != 0 && c == v.stop_cyc);
                trig_hit  = (c >= v.trig_cyc);
                drive_words(v.rle, c);
                if (c >= 1 && (!v.rle || rle_valid) && pushed < v.exp_writes) begin
                    d = v.rle ? rle_data : raw_data;
                    exp_q.push_back({24'(pushed % v.depth), d});
                    pushed++;
                end
                if (c == 1) begin
                    chk("run_busy", 64'(cap_busy), 64'd1);
                    chk("run_done_clr", 64'(cap_done), 64'd0);
                    chk("run_abort_clr", 64'(cap_aborted), 64'd0);
                    chk("run_enc_rst", 64'(enc_rst), 64'd0);
                end
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got state %0d expected 4", state);
        end
        cfg_start = 0;
        cfg_stop  = 0;
        trig_hit  = 0;
        rle_valid = 0;
        if (v.exp_trig_pos >= 0) chk("trig_pos", 64'(trig_pos), 64'(v.exp_trig_pos));
        chk("end_done", 64'(cap_done), 64'd1);
        chk("end_aborted", 64'(cap_aborted), 64'(v.exp_aborted));
        chk("end_busy", 64'(cap_busy), 64'd0);
        chk("end_enc_rst", 64'(enc_rst), 64'd1);
        chk("end_state", 64'(state), 64'd4);
        repeat (3) @(negedge core_clk);
        chk("write_count", 64'(wr_seen), 64'(v.exp_writes));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    cap_vec_t vecs[10];

    initial begin
        //              rle depth pre trig stop tpos writes abort
        vecs[0] = '{1'b0, 8, 3,  4,    0, 3,  8,  1'b0};
        vecs[1] = '{1'b0, 8, 3,  6,    0, 5,  10, 1'b0};
        vecs[2] = '{1'b1, 4, 0,  1,    0, 0,  4,  1'b0};
        vecs[3] = '{1'b0, 6, 2,  0,    0, 2,  6,  1'b0};
        vecs[4] = '{1'b0, 4, 3,  14,   0, 1,  14, 1'b0};
        vecs[5] = '{1'b0, 4, 9,  4,    0, 3,  4,  1'b0};
        vecs[6] = '{1'b0, 3, 0,  2,    0, 1,  4,  1'b0};
        vecs[7] = '{1'b0, 1, 0,  1,    0, 0,  1,  1'b0};
        vecs[8] = '{1'b0, 8, 2,  1000, 5, -1, 5,  1'b1};
        vecs[9] = '{1'b1, 6, 2,  1,    0, 2,  6,  1'b0};

        // Reset values, both while held and after release.
        repeat (3) @(negedge core_clk);
        check_reset_values("rst_held");
        core_rst = 1'b0;
        @(negedge core_clk);
        check_reset_values("rst_rel");

        // Start and stop together in IDLE: stop wins, nothing is armed.
        wr_seen = 0;
        cfg_depth = 25'd4;
        cfg_pretrig = 25'd1;
        cfg_start = 1'b1;
        cfg_stop = 1'b1;
        @(negedge core_clk);
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        chk("ss_state", 64'(state), 64'd0);
        chk("ss_busy", 64'(cap_busy), 64'd0);
        @(negedge core_clk);
        chk("ss_writes", 64'(wr_seen), 64'd0);

        // Ignored restart while busy, then reset in the middle of POST.
        wr_seen = 0;
        cfg_rle_en = 1'b0;
        cfg_pretrig = 25'd4;
        for (int c = 0; c <= 8; c++) begin
            @(negedge core_clk);
            cfg_start = (c == 0 || c == 3);
            cfg_depth = (c == 3) ? 25'd2 : 25'd16;
            trig_hit = (c >= 6);
            drive_words(1'b0, c);
            if (c >= 1 && c <= 7) exp_q.push_back({24'(c - 1), raw_data});
            if (c == 4) chk("restart_ignored_state", 64'(state), 64'd1);
            if (c == 8) begin
                chk("mid_post_state", 64'(state), 64'd3);
                core_rst = 1'b1;
            end
        end
        @(negedge core_clk);
        cfg_start = 1'b0;
        trig_hit = 1'b0;
        check_reset_values("rst_mid");
        core_rst = 1'b0;
        repeat (2) @(negedge core_clk);
        chk("rst_mid_writes", 64'(wr_seen), 64'd7);
        chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        for (int i = 0; i < 10; i++) begin
            run_capture(vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
